// File: rtl/ysyx_22041211_pkg.sv
// Shared definitions for the ysyx_22041211 multi-cycle control path.
// Holds the control FSM state encoding and the number of states.
package ysyx_22041211_pkg;

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd5
    } state_t;

    localparam int STATE_CNT = 6;

endpackage

// File: rtl/ysyx_22041211_perf_cnt.sv
// Cycle and retired-instruction counters with independent enables.
// Both counters wrap silently modulo 2^CNT_W.
module ysyx_22041211_perf_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cyc_en,
    input  logic             ret_en,
    output logic [CNT_W-1:0] cycle,
    output logic [CNT_W-1:0] instret
);

    always_ff @(posedge clk) begin
        if (rst) begin
            cycle   <= '0;
            instret <= '0;
        end else begin
            if (cyc_en) cycle   <= cycle + CNT_W'(1);
            if (ret_en) instret <= instret + CNT_W'(1);
        end
    end

endmodule

// File: rtl/ysyx_22041211_ctrl_fsm.sv
// Multi-cycle core sequencer: IF -> ID -> EX -> (MEM) -> WB, with a terminal HALT.
// Drives fetch/LSU requests, writeback strobes and the performance counters.
module ysyx_22041211_ctrl_fsm
    import ysyx_22041211_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ifu_rvalid_i,
    input  logic             dec_load_i,
    input  logic             dec_store_i,
    input  logic             dec_wd_i,
    input  logic             dec_ebreak_i,
    input  logic             dec_illegal_i,
    input  logic             lsu_rvalid_i,
    output logic             ifu_req_o,
    output logic             inst_we_o,
    output logic             lsu_req_o,
    output logic             lsu_wen_o,
    output logic             reg_we_o,
    output logic             pc_we_o,
    output logic             halt_o,
    output logic             trap_o,
    output logic [CNT_W-1:0] cycle_o,
    output logic [CNT_W-1:0] instret_o
);

    state_t state_q, state_d;
    logic   load_q, store_q, wd_q, trap_q;

    logic ifu_req, inst_we, lsu_req, lsu_wen, reg_we, pc_we, halt, trap;
    logic [CNT_W-1:0] cycle, instret;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IF;
            load_q  <= 1'b0;
            store_q <= 1'b0;
            wd_q    <= 1'b0;
            trap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            // Class flags are captured only while the decoder output is valid.
            if (state_q == S_ID) begin
                load_q  <= dec_load_i;
                store_q <= dec_store_i;
                wd_q    <= dec_wd_i;
                trap_q  <= dec_illegal_i;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ifu_req = 1'b0;
        inst_we = 1'b0;
        lsu_req = 1'b0;
        lsu_wen = 1'b0;
        reg_we  = 1'b0;
        pc_we   = 1'b0;
        halt    = 1'b0;
        trap    = 1'b0;
        case (state_q)
            S_IF: begin
                ifu_req = 1'b1;
                if (ifu_rvalid_i) begin
                    inst_we = 1'b1;
                    state_d = S_ID;
                end
            end
            S_ID: begin
                // Illegal wins over ebreak so a bad opcode always reports a trap.
                if (dec_illegal_i || dec_ebreak_i) state_d = S_HALT;
                else                               state_d = S_EX;
            end
            S_EX: begin
                state_d = (load_q || store_q) ? S_MEM : S_WB;
            end
            S_MEM: begin
                lsu_req = 1'b1;
                lsu_wen = store_q;
                if (lsu_rvalid_i) state_d = S_WB;
            end
            S_WB: begin
                pc_we   = 1'b1;
                reg_we  = wd_q && !store_q;
                state_d = S_IF;
            end
            S_HALT: begin
                halt = 1'b1;
                trap = trap_q;
            end
            default: state_d = S_IF;
        endcase
    end

    ysyx_22041211_perf_cnt #(
        .CNT_W(CNT_W)
    ) u_perf_cnt (
        .clk    (clk),
        .rst    (rst),
        .cyc_en (state_q != S_HALT),
        .ret_en (state_q == S_WB),
        .cycle  (cycle),
        .instret(instret)
    );

    // Everything is forced low while reset is held, independent of the stored state.
    assign ifu_req_o = !rst && ifu_req;
    assign inst_we_o = !rst && inst_we;
    assign lsu_req_o = !rst && lsu_req;
    assign lsu_wen_o = !rst && lsu_wen;
    assign reg_we_o  = !rst && reg_we;
    assign pc_we_o   = !rst && pc_we;
    assign halt_o    = !rst && halt;
    assign trap_o    = !rst && trap;
    assign cycle_o   = rst ? '0 : cycle;
    assign instret_o = rst ? '0 : instret;

endmodule

// File: tb/tb_ysyx_22041211_ctrl_fsm.sv
// Directed per-cycle vector bench for the control FSM, plus a narrow-counter wrap check.
module tb_ysyx_22041211_ctrl_fsm;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance (CNT_W = 32)
    logic rst, ifu_rvalid, dec_load, dec_store, dec_wd, dec_ebreak, dec_illegal, lsu_rvalid;
    logic ifu_req, inst_we, lsu_req, lsu_wen, reg_we, pc_we, halt, trap;
    logic [31:0] cycle, instret;

    ysyx_22041211_ctrl_fsm #(.CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .ifu_rvalid_i(ifu_rvalid), .dec_load_i(dec_load), .dec_store_i(dec_store),
        .dec_wd_i(dec_wd), .dec_ebreak_i(dec_ebreak), .dec_illegal_i(dec_illegal),
        .lsu_rvalid_i(lsu_rvalid),
        .ifu_req_o(ifu_req), .inst_we_o(inst_we), .lsu_req_o(lsu_req), .lsu_wen_o(lsu_wen),
        .reg_we_o(reg_we), .pc_we_o(pc_we), .halt_o(halt), .trap_o(trap),
        .cycle_o(cycle), .instret_o(instret)
    );

    // Narrow instance for counter wrap-around
    logic n_rst, n_ifv, n_wd;
    logic n_ifu_req, n_inst_we, n_lsu_req, n_lsu_wen, n_reg_we, n_pc_we, n_halt, n_trap;
    logic [3:0] n_cycle, n_instret;

    ysyx_22041211_ctrl_fsm #(.CNT_W(4)) dut_n (
        .clk(clk), .rst(n_rst),
        .ifu_rvalid_i(n_ifv), .dec_load_i(1'b0), .dec_store_i(1'b0),
        .dec_wd_i(n_wd), .dec_ebreak_i(1'b0), .dec_illegal_i(1'b0),
        .lsu_rvalid_i(1'b0),
        .ifu_req_o(n_ifu_req), .inst_we_o(n_inst_we), .lsu_req_o(n_lsu_req), .lsu_wen_o(n_lsu_wen),
        .reg_we_o(n_reg_we), .pc_we_o(n_pc_we), .halt_o(n_halt), .trap_o(n_trap),
        .cycle_o(n_cycle), .instret_o(n_instret)
    );

    // in  = {rst, ifu_rvalid, load, store, wd, ebreak, illegal, lsu_rvalid}
    // exp = {ifu_req, inst_we, lsu_req, lsu_wen, reg_we, pc_we, halt, trap}
    typedef struct {
        string       name;
        logic [7:0]  in;
        logic [7:0]  exp;
        logic [31:0] cyc;
        logic [31:0] ir;
    } vec_t;

    vec_t vecs[$];
    int errors = 0;
    int checks = 0;

    function automatic void add(string name, logic [7:0] in, logic [7:0] exp,
                                logic [31:0] cyc, logic [31:0] ir);
        vec_t v;
        v.name = name; v.in = in; v.exp = exp; v.cyc = cyc; v.ir = ir;
        vecs.push_back(v);
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply(logic [7:0] in);
        {rst, ifu_rvalid, dec_load, dec_store, dec_wd, dec_ebreak, dec_illegal, lsu_rvalid} = in;
    endtask

    initial begin
        apply(8'b1000_0000);
        n_rst = 1'b1; n_ifv = 1'b0; n_wd = 1'b0;

        add("reset0",      8'b1000_0000, 8'b0000_0000,  0, 0);
        add("reset1",      8'b1000_0000, 8'b0000_0000,  0, 0);
        // ALU: IF, ID, EX, WB
        add("alu_if",      8'b0100_0000, 8'b1100_0000,  0, 0);
        add("alu_id",      8'b0000_1000, 8'b0000_0000,  1, 0);
        add("alu_ex",      8'b0000_0000, 8'b0000_0000,  2, 0);
        add("alu_wb",      8'b0000_0000, 8'b0000_1100,  3, 0);
        // Load with three MEM cycles; stray lsu_rvalid in EX is ignored
        add("ld_if",       8'b0100_0000, 8'b1100_0000,  4, 1);
        add("ld_id",       8'b0010_1000, 8'b0000_0000,  5, 1);
        add("ld_ex",       8'b0000_0001, 8'b0000_0000,  6, 1);
        add("ld_mem1",     8'b0000_0000, 8'b0010_0000,  7, 1);
        add("ld_mem2",     8'b0000_0000, 8'b0010_0000,  8, 1);
        add("ld_mem3",     8'b0000_0001, 8'b0010_0000,  9, 1);
        add("ld_wb",       8'b0000_0000, 8'b0000_1100, 10, 1);
        // Store with wd=1 and a two-cycle fetch stall
        add("st_if_wait1", 8'b0000_0000, 8'b1000_0000, 11, 2);
        add("st_if_wait2", 8'b0000_0000, 8'b1000_0000, 12, 2);
        add("st_if",       8'b0100_0000, 8'b1100_0000, 13, 2);
        add("st_id",       8'b0001_1000, 8'b0000_0000, 14, 2);
        add("st_ex",       8'b0000_0000, 8'b0000_0000, 15, 2);
        add("st_mem",      8'b0000_0001, 8'b0011_0000, 16, 2);
        add("st_wb",       8'b0000_0000, 8'b0000_0100, 17, 2);
        // ebreak: halt without trap, inputs ignored in HALT
        add("eb_if",       8'b0100_0000, 8'b1100_0000, 18, 3);
        add("eb_id",       8'b0000_0100, 8'b0000_0000, 19, 3);
        add("eb_halt1",    8'b0100_0001, 8'b0000_0010, 20, 3);
        add("eb_halt2",    8'b0100_0001, 8'b0000_0010, 20, 3);
        add("eb_reset",    8'b1000_0000, 8'b0000_0000,  0, 0);
        // illegal + ebreak together: trap wins, cycle frozen for 10 cycles
        add("il_if",       8'b0100_0000, 8'b1100_0000,  0, 0);
        add("il_id",       8'b0000_0110, 8'b0000_0000,  1, 0);
        for (int i = 0; i < 10; i++)
            add("il_halt",  8'b0100_0000, 8'b0000_0011,  2, 0);
        add("il_reset",    8'b1000_0000, 8'b0000_0000,  0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            apply(vecs[i].in);
            #1;
            check({vecs[i].name, "_strobes"},
                  {24'd0, ifu_req, inst_we, lsu_req, lsu_wen, reg_we, pc_we, halt, trap},
                  {24'd0, vecs[i].exp});
            check({vecs[i].name, "_cycle"},   cycle,   vecs[i].cyc);
            check({vecs[i].name, "_instret"}, instret, vecs[i].ir);
        end

        // Reset pulsed in the middle of an LSU wait
        @(negedge clk); apply(8'b0100_0000);
        @(negedge clk); apply(8'b0001_0000);
        @(negedge clk); apply(8'b0000_0000);
        @(negedge clk); apply(8'b0000_0000); #1;
        check("mid_mem_req", {30'd0, lsu_req, lsu_wen}, 32'd3);
        @(negedge clk); apply(8'b1000_0000); #1;
        check("mid_rst_strobes",
              {24'd0, ifu_req, inst_we, lsu_req, lsu_wen, reg_we, pc_we, halt, trap}, 32'd0);
        check("mid_rst_cycle", cycle, 32'd0);
        @(negedge clk); apply(8'b0000_0001); #1;
        check("post_rst_strobes",
              {24'd0, ifu_req, inst_we, lsu_req, lsu_wen, reg_we, pc_we, halt, trap}, 32'h80);
        check("post_rst_cycle",   cycle,   32'd0);
        check("post_rst_instret", instret, 32'd0);

        // Narrow-counter wrap: cycle while stalled in IF, instret over 16 ALU instructions
        @(negedge clk); n_rst = 1'b0;
        repeat (15) @(negedge clk);
        #1 check("n_cycle_max", {28'd0, n_cycle}, 32'd15);
        @(negedge clk);
        #1 check("n_cycle_wrap", {28'd0, n_cycle}, 32'd0);
        n_rst = 1'b1;
        @(negedge clk); n_rst = 1'b0; n_ifv = 1'b1; n_wd = 1'b1;
        repeat (60) @(negedge clk);
        #1 check("n_instret_max", {28'd0, n_instret}, 32'd15);
        repeat (4) @(negedge clk);
        #1 check("n_instret_wrap", {28'd0, n_instret}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ysyx_22041211_ctrl_fsm.md
YSYX_22041211_CTRL_FSM -- requirements
Module: ysyx_22041211_ctrl_fsm

Interface
REQ-001 SHALL have parameter: CNT_W, 32, width of cycle and instret counters.
REQ-002 SHALL have port: clk  input  1  core clock, the only clock.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: ifu_rvalid_i  input  1  fetched instruction valid on IFU data bus.
REQ-005 SHALL have port: dec_load_i  input  1  decoded instruction is a load.
REQ-006 SHALL have port: dec_store_i  input  1  decoded instruction is a store.
REQ-007 SHALL have port: dec_wd_i  input  1  decoded instruction writes rd.
REQ-008 SHALL have port: dec_ebreak_i  input  1  decoded instruction is ebreak.
REQ-009 SHALL have port: dec_illegal_i  input  1  opcode not recognised by decoder.
REQ-010 SHALL have port: lsu_rvalid_i  input  1  LSU access complete.
REQ-011 SHALL have port: ifu_req_o  output  1  fetch request.
REQ-012 SHALL have port: inst_we_o  output  1  latch fetched instruction into decoder input register.
REQ-013 SHALL have port: lsu_req_o / lsu_wen_o  output  1 / 1  LSU request / write-enable.
REQ-014 SHALL have port: reg_we_o / pc_we_o  output  1 / 1  GPR write / PC update strobes.
REQ-015 SHALL have port: halt_o / trap_o  output  1 / 1  core halted / halted on illegal instruction.
REQ-016 SHALL have port: cycle_o / instret_o  output  CNT_W / CNT_W  cycle and retired-instruction counters.

Function
REQ-017 SHALL implement states IF, ID, EX, MEM, WB, HALT, one-hot or binary, encoded in package.
REQ-018 IF: ifu_req_o=1 held every cycle until ifu_rvalid_i=1; that cycle inst_we_o=1 (combinational, one cycle) and next state ID.
REQ-019 ID: exactly one cycle; register dec_load_i, dec_store_i, dec_wd_i into internal class flags; if dec_illegal_i -> HALT with trap set; else if dec_ebreak_i -> HALT; else -> EX.
REQ-020 dec_illegal_i SHALL take priority over dec_ebreak_i when both high.
REQ-021 EX: exactly one cycle; -> MEM if load or store flag set, else -> WB.
REQ-022 MEM: lsu_req_o=1 and lsu_wen_o=store flag, held until lsu_rvalid_i=1; then -> WB; lsu_rvalid_i outside MEM SHALL be ignored.
REQ-023 WB: one cycle; pc_we_o=1; reg_we_o = wd flag AND NOT store flag; instret increments; -> IF.
REQ-024 HALT: absorbing until rst; halt_o=1; trap_o=1 only if entered on illegal; all request/strobe outputs 0.
REQ-025 Minimum latency: ALU instruction 4 cycles (IF with rvalid on first cycle, ID, EX, WB); load/store 5 cycles plus LSU wait.
REQ-026 cycle_o SHALL increment every cycle not in HALT; both counters wrap modulo 2^CNT_W without flag.
REQ-027 ifu_req_o, lsu_req_o, lsu_wen_o, reg_we_o, pc_we_o, inst_we_o SHALL never be high outside their stated states.

Reset
REQ-028 rst=1 at any clock edge SHALL force state IF, clear class flags, counters, halt_o, trap_o; outstanding IFU/LSU request is abandoned.
REQ-029 During rst=1 all outputs SHALL be 0; first request ifu_req_o=1 appears the cycle after rst falls.

Structure
REQ-030 State encoding typedef and state count constant SHALL live in shared package ysyx_22041211_pkg.
REQ-031 Counters SHALL be one sub-module ysyx_22041211_perf_cnt (cycle + instret, enable and wrap behaviour); FSM stays in top.

Verification
REQ-032 ALU inst, ifu_rvalid_i high on first IF cycle, dec_wd_i=1 -> states IF,ID,EX,WB; reg_we_o and pc_we_o single pulse on cycle 4; instret_o=1.
REQ-033 Load with lsu_rvalid_i after 3 MEM cycles -> lsu_req_o high 3 cycles, lsu_wen_o=0, reg_we_o=1 in WB, total 7 cycles.
REQ-034 Store, dec_wd_i=1 -> lsu_wen_o=1 in MEM, reg_we_o=0 in WB.
REQ-035 dec_illegal_i=1 and dec_ebreak_i=1 in ID -> HALT, halt_o=1, trap_o=1, cycle_o frozen over 10 further cycles.
REQ-036 rst pulsed mid-MEM -> next cycle all outputs 0, counters 0, state IF; preload cycle_o to 0xFFFFFFFF -> wraps to 0.
